// File: rtl/vram_wr_sched_if.sv
// Handshake and write-port bundle for vram_wr_sched: two pixel requesters,
// clear control, the registered VRAM write port, status and counters.
interface vram_wr_sched_if #(
  parameter int CNT_W = 16
);
  logic             iA_valid;
  logic [7:0]       iA_x;
  logic [7:0]       iA_y;
  logic [8:0]       iA_rgb;
  logic             oA_ready;

  logic             iB_valid;
  logic [7:0]       iB_x;
  logic [7:0]       iB_y;
  logic [8:0]       iB_rgb;
  logic             oB_ready;

  logic             iClear_req;
  logic             iClear_color_sel;
  logic [8:0]       iClear_color;

  logic             oWr_en;
  logic [7:0]       oWr_x;
  logic [7:0]       oWr_y;
  logic [8:0]       oWr_rgb;
  logic             oBusy;
  logic             oClear_done;
  logic [CNT_W-1:0] oA_cnt;
  logic [CNT_W-1:0] oB_cnt;

  modport slave (
    input  iA_valid, iA_x, iA_y, iA_rgb,
    input  iB_valid, iB_x, iB_y, iB_rgb,
    input  iClear_req, iClear_color_sel, iClear_color,
    output oA_ready, oB_ready,
    output oWr_en, oWr_x, oWr_y, oWr_rgb, oBusy, oClear_done, oA_cnt, oB_cnt
  );

  modport master (
    output iA_valid, iA_x, iA_y, iA_rgb,
    output iB_valid, iB_x, iB_y, iB_rgb,
    output iClear_req, iClear_color_sel, iClear_color,
    input  oA_ready, oB_ready,
    input  oWr_en, oWr_x, oWr_y, oWr_rgb, oBusy, oClear_done, oA_cnt, oB_cnt
  );
endinterface

// File: rtl/vram_wr_sched.sv
// VRAM write-port scheduler: round-robin A/B arbitration plus a full-frame clear sweep.
// Optional macro VRAM_WR_SCHED_VBLANK_EN restricts grants and clear start to vertical blank.
module vram_wr_sched #(
  parameter logic [8:0] CLR_COLOR_DEFAULT = 9'h000,
  parameter int         CNT_W             = 16
) (
  input  logic iCLK,
  input  logic iRST_N,
`ifdef VRAM_WR_SCHED_VBLANK_EN
  input  logic iVBlank,
`endif
  vram_wr_sched_if.slave bus
);

  typedef enum logic {ST_ARB, ST_CLEAR} state_t;

  state_t           r_state;
  logic             r_last_b;    // 1: B was granted last, so A wins the next tie
  logic [15:0]      r_clr_cnt;
  logic             r_wr_en;
  logic [7:0]       r_wr_x;
  logic [7:0]       r_wr_y;
  logic [8:0]       r_wr_rgb;
  logic             r_busy;
  logic             r_clear_done;
  logic [CNT_W-1:0] r_a_cnt;
  logic [CNT_W-1:0] r_b_cnt;

  logic        w_gate;
  logic        w_clear_start;
  logic        w_grant_en;
  logic        w_grant_a;
  logic        w_grant_b;
  logic [15:0] w_clr_next;
  logic [8:0]  w_clr_color;

  // Readies are combinational, so they are also forced low while reset is held.
`ifdef VRAM_WR_SCHED_VBLANK_EN
  assign w_gate = iRST_N & iVBlank;
`else
  assign w_gate = iRST_N;
`endif

  assign w_clear_start = (r_state == ST_ARB) && bus.iClear_req && w_gate;
  assign w_grant_en    = (r_state == ST_ARB) && !bus.iClear_req && w_gate;
  assign w_grant_a     = w_grant_en && bus.iA_valid && (!bus.iB_valid || r_last_b);
  assign w_grant_b     = w_grant_en && bus.iB_valid && (!bus.iA_valid || !r_last_b);
  assign w_clr_next    = r_clr_cnt + 16'd1;
  assign w_clr_color   = bus.iClear_color_sel ? bus.iClear_color : CLR_COLOR_DEFAULT;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state      <= ST_ARB;
      r_last_b     <= 1'b1;
      r_clr_cnt    <= '0;
      r_wr_en      <= 1'b0;
      r_wr_x       <= '0;
      r_wr_y       <= '0;
      r_wr_rgb     <= '0;
      r_busy       <= 1'b0;
      r_clear_done <= 1'b0;
      r_a_cnt      <= '0;
      r_b_cnt      <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          r_clear_done <= 1'b0;
          if (w_clear_start) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_wr_en   <= 1'b1;
            r_wr_x    <= '0;
            r_wr_y    <= '0;
            r_wr_rgb  <= w_clr_color;   // held for the whole sweep
            r_busy    <= 1'b1;
          end else if (w_grant_a) begin
            r_wr_en  <= 1'b1;
            r_wr_x   <= bus.iA_x;
            r_wr_y   <= bus.iA_y;
            r_wr_rgb <= bus.iA_rgb;
            r_last_b <= 1'b0;
            r_a_cnt  <= r_a_cnt + 1'b1;
          end else if (w_grant_b) begin
            r_wr_en  <= 1'b1;
            r_wr_x   <= bus.iB_x;
            r_wr_y   <= bus.iB_y;
            r_wr_rgb <= bus.iB_rgb;
            r_last_b <= 1'b1;
            r_b_cnt  <= r_b_cnt + 1'b1;
          end else begin
            r_wr_en <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (r_clr_cnt == 16'hFFFF) begin
            r_state      <= ST_ARB;
            r_clr_cnt    <= '0;
            r_wr_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_clear_done <= 1'b0;
          end else begin
            r_clr_cnt    <= w_clr_next;
            r_wr_x       <= w_clr_next[7:0];
            r_wr_y       <= w_clr_next[15:8];
            r_clear_done <= (w_clr_next == 16'hFFFF);
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  assign bus.oA_ready    = w_grant_a;
  assign bus.oB_ready    = w_grant_b;
  assign bus.oWr_en      = r_wr_en;
  assign bus.oWr_x       = r_wr_x;
  assign bus.oWr_y       = r_wr_y;
  assign bus.oWr_rgb     = r_wr_rgb;
  assign bus.oBusy       = r_busy;
  assign bus.oClear_done = r_clear_done;
  assign bus.oA_cnt      = r_a_cnt;
  assign bus.oB_cnt      = r_b_cnt;

endmodule

// File: tb/tb_vram_wr_sched.sv
// Self-checking bench for vram_wr_sched: arbitration model feeding a write
// scoreboard, full clear sweeps, mid-sweep reset, optional vblank gating.
module tb_vram_wr_sched;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vram_wr_sched_if #(.CNT_W(16)) bus ();

`ifdef VRAM_WR_SCHED_VBLANK_EN
  logic vblank = 1'b1;
`endif

  vram_wr_sched #(
    .CLR_COLOR_DEFAULT(9'h000),
    .CNT_W            (16)
  ) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
`ifdef VRAM_WR_SCHED_VBLANK_EN
    .iVBlank(vblank),
`endif
    .bus    (bus)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [8:0] rgb;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks   = 0;
  int          n_errors   = 0;
  int          sweep_errs = 0;
  int          run        = 0;
  logic        m_last_b   = 1'b1;
  logic [15:0] m_a_cnt    = '0;
  logic [15:0] m_b_cnt    = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"}, bus.oWr_en, 0);
    check({tag, "_wr_x"},  bus.oWr_x, 0);
    check({tag, "_wr_y"},  bus.oWr_y, 0);
    check({tag, "_rgb"},   bus.oWr_rgb, 0);
    check({tag, "_busy"},  bus.oBusy, 0);
    check({tag, "_done"},  bus.oClear_done, 0);
    check({tag, "_a_cnt"}, bus.oA_cnt, 0);
    check({tag, "_b_cnt"}, bus.oB_cnt, 0);
    check({tag, "_a_rdy"}, bus.oA_ready, 0);
    check({tag, "_b_rdy"}, bus.oB_ready, 0);
  endtask

  // One ARB-mode cycle with iClear_req low: model the grant, check readies,
  // push the expected write, then check the registered write one edge later.
  task automatic cycle();
    logic ga, gb, gate;
    wr_t  e;
    @(negedge clk);
    gate = rst_n;
`ifdef VRAM_WR_SCHED_VBLANK_EN
    gate = gate & vblank;
`endif
    ga = gate && bus.iA_valid && (!bus.iB_valid || m_last_b);
    gb = gate && bus.iB_valid && (!bus.iA_valid || !m_last_b);
    check("a_ready", bus.oA_ready, ga);
    check("b_ready", bus.oB_ready, gb);
    if (ga) begin
      e.x = bus.iA_x; e.y = bus.iA_y; e.rgb = bus.iA_rgb;
      exp_q.push_back(e);
      m_last_b = 1'b0;
      m_a_cnt++;
    end else if (gb) begin
      e.x = bus.iB_x; e.y = bus.iB_y; e.rgb = bus.iB_rgb;
      exp_q.push_back(e);
      m_last_b = 1'b1;
      m_b_cnt++;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("wr_en", bus.oWr_en, 1);
      check("wr_x", bus.oWr_x, e.x);
      check("wr_y", bus.oWr_y, e.y);
      check("wr_rgb", bus.oWr_rgb, e.rgb);
    end else begin
      check("wr_idle", bus.oWr_en, 0);
    end
    check("a_cnt", bus.oA_cnt, m_a_cnt);
    check("b_cnt", bus.oB_cnt, m_b_cnt);
    check("done_idle", bus.oClear_done, 0);
    run = bus.oWr_en ? run + 1 : 0;
  endtask

  // One sweep cycle; mismatches are tallied and reported once per sweep.
  task automatic sweep_cycle(input int i, input logic [8:0] col);
    logic [15:0] a;
    a = i[15:0];
    if (bus.oWr_en !== 1'b1 || bus.oBusy !== 1'b1 || bus.oWr_x !== a[7:0] ||
        bus.oWr_y !== a[15:8] || bus.oWr_rgb !== col ||
        bus.oClear_done !== (i == 65535) || bus.oA_ready !== 1'b0 ||
        bus.oB_ready !== 1'b0)
      sweep_errs++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [7:0] x, input logic [7:0] y, input logic [8:0] rgb);
    bus.iA_valid = v; bus.iA_x = x; bus.iA_y = y; bus.iA_rgb = rgb;
  endtask

  task automatic set_b(input logic v, input logic [7:0] x, input logic [7:0] y, input logic [8:0] rgb);
    bus.iB_valid = v; bus.iB_x = x; bus.iB_y = y; bus.iB_rgb = rgb;
  endtask

  initial begin
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    bus.iClear_req       = 1'b0;
    bus.iClear_color_sel = 1'b0;
    bus.iClear_color     = 9'h000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) cycle();

    // Single A transfer
    set_a(1, 8'd3, 8'd5, 9'h1FF);
    cycle();
    check("a_cnt_first", bus.oA_cnt, 1);
    set_a(0, 0, 0, 0);
    cycle();

    // Both valid for six cycles: strict alternation, back-to-back writes
    for (int i = 0; i < 6; i++) begin
      set_a(1, 8'(i), 8'(10 + i), 9'(9'h040 + i));
      set_b(1, 8'(8'h80 + i), 8'(20 + i), 9'(9'h100 + i));
      cycle();
    end
    check("run_of_6", run, 6);
    check("a_cnt_6", bus.oA_cnt, 4);
    check("b_cnt_6", bus.oB_cnt, 3);
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    cycle();

    // B alone, then a tie: A must win
    for (int i = 0; i < 3; i++) begin
      set_b(1, 8'(8'hC0 + i), 8'hEE, 9'h155);
      cycle();
    end
    set_a(1, 8'h11, 8'h22, 9'h033);
    #2;
    check("tie_goes_a", bus.oA_ready, 1);
    check("tie_b_waits", bus.oB_ready, 0);
    cycle();
    cycle();
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    cycle();

    // Clear with alternate colour, A held valid throughout
    set_a(1, 8'd7, 8'd8, 9'h001);
    bus.iClear_req       = 1'b1;
    bus.iClear_color_sel = 1'b1;
    bus.iClear_color     = 9'h0AA;
    @(negedge clk);
    check("clr1_a_rdy", bus.oA_ready, 0);
    check("clr1_b_rdy", bus.oB_ready, 0);
    @(posedge clk);
    #1;
    bus.iClear_req = 1'b0;
    sweep_errs = 0;
    for (int i = 0; i < 65536; i++) sweep_cycle(i, 9'h0AA);
    check("sweep1_errs", sweep_errs, 0);
    check("clr1_busy_off", bus.oBusy, 0);
    check("clr1_wr_off", bus.oWr_en, 0);
    check("clr1_done_off", bus.oClear_done, 0);
    check("clr1_a_rdy_back", bus.oA_ready, 1);
    cycle();
    set_a(0, 0, 0, 0);
    cycle();

    // Clear vs A in the same cycle, re-request mid-sweep, reset at sweep cycle 1000
    set_a(1, 8'h33, 8'h44, 9'h123);
    bus.iClear_req       = 1'b1;
    bus.iClear_color_sel = 1'b0;
    bus.iClear_color     = 9'h0AA;
    @(negedge clk);
    check("clr2_a_rdy", bus.oA_ready, 0);
    @(posedge clk);
    #1;
    bus.iClear_req = 1'b0;
    sweep_errs = 0;
    for (int i = 0; i < 1000; i++) begin
      bus.iClear_req = (i == 500);
      sweep_cycle(i, 9'h000);
    end
    bus.iClear_req = 1'b0;
    check("sweep2_errs", sweep_errs, 0);
    check("sweep2_addr_lo", bus.oWr_x, 1000 % 256);
    check("sweep2_addr_hi", bus.oWr_y, 1000 / 256);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    set_a(0, 0, 0, 0);
    exp_q.delete();
    m_last_b = 1'b1;
    m_a_cnt  = '0;
    m_b_cnt  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_busy", bus.oBusy, 0);
      cycle();
    end

`ifdef VRAM_WR_SCHED_VBLANK_EN
    // Grants blocked outside vertical blank, released the cycle it rises
    vblank = 1'b0;
    set_a(1, 8'h55, 8'h66, 9'h0F0);
    for (int i = 0; i < 3; i++) cycle();
    check("vb_blocked_cnt", bus.oA_cnt, 0);
    vblank = 1'b1;
    #1;
    check("vb_ready", bus.oA_ready, 1);
    cycle();
    set_a(0, 0, 0, 0);
    cycle();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
